// File: rtl/phase_sweep_gen.sv
// ============================================================================
// Module   : phase_sweep_gen
// Brief    : Phase-word source for the CORDIC sine/cosine generator. Emits
//            wrapped radian phase (signed 1.2.13) over a valid/ready stream,
//            either as a constant-increment tone or as a linear increment
//            sweep (chirp) with programmable dwell. The phase only advances
//            on accepted beats, so back-pressure never distorts the waveform.
// Options  : PHASE_OFFSET_EN - adds i_offset, a latched phase offset applied
//            combinationally to the output word (accumulator unaffected).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_sweep_gen #(
  parameter int PW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          i_mode,
  input  logic          i_loop,
  input  logic [PW-1:0] i_start_inc,
  input  logic [PW-1:0] i_stop_inc,
  input  logic [PW-1:0] i_step_inc,
  input  logic [DW-1:0] i_dwell,
`ifdef PHASE_OFFSET_EN
  input  logic [PW-1:0] i_offset,
`endif
  output logic [PW-1:0] m_phase_tdata,
  output logic          m_phase_tvalid,
  input  logic          m_phase_tready,
  output logic          m_phase_tlast,
  output logic          o_busy
);

  // +pi in 1.2.13 is 25736; the full turn is twice that.
  localparam int                    PI_VAL   = 25736;
  localparam logic signed [PW-1:0]  PI_POS   = PW'(PI_VAL);
  localparam logic signed [PW-1:0]  PI_NEG   = -PI_POS;
  localparam logic signed [PW+1:0]  PI_POS_X = (PW+2)'(PI_VAL);
  localparam logic signed [PW+1:0]  PI_NEG_X = -PI_POS_X;
  localparam logic signed [PW+1:0]  TWO_PI_X = (PW+2)'(2 * PI_VAL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Limit an increment to one half-turn so a single wrap step always suffices.
  function automatic logic signed [PW-1:0] clamp_inc(input logic [PW-1:0] v);
    logic signed [PW-1:0] s;
    s = $signed(v);
    if (s > PI_POS)
      clamp_inc = PI_POS;
    else if (s < PI_NEG)
      clamp_inc = PI_NEG;
    else
      clamp_inc = s;
  endfunction

  // Add two in-range phases in PW+2 bits and fold the result back to [-pi, pi].
  function automatic logic signed [PW-1:0] wrap_add(input logic signed [PW-1:0] a,
                                                    input logic signed [PW-1:0] b);
    logic signed [PW+1:0] s;
    s = {{2{a[PW-1]}}, a} + {{2{b[PW-1]}}, b};
    if (s > PI_POS_X)
      s = s - TWO_PI_X;
    else if (s < PI_NEG_X)
      s = s + TWO_PI_X;
    wrap_add = s[PW-1:0];
  endfunction

  // True when stepping inc once more would carry it past stop (a zero step
  // ends the pass after a single dwell period).
  function automatic logic pass_end(input logic signed [PW-1:0] inc_v,
                                    input logic signed [PW-1:0] step_v,
                                    input logic signed [PW-1:0] stop_v);
    logic signed [PW:0] n;
    logic signed [PW:0] stop_x;
    n      = {inc_v[PW-1], inc_v} + {step_v[PW-1], step_v};
    stop_x = {stop_v[PW-1], stop_v};
    if (step_v == '0)
      pass_end = 1'b1;
    else if (!step_v[PW-1])
      pass_end = (n > stop_x);
    else
      pass_end = (n < stop_x);
  endfunction

  state_t               state;
  logic signed [PW-1:0] phase;
  logic signed [PW-1:0] inc;
  logic signed [PW-1:0] start_inc_q;
  logic signed [PW-1:0] stop_inc_q;
  logic signed [PW-1:0] step_inc_q;
  logic [DW-1:0]        dwell_max;
  logic [DW-1:0]        dwell_cnt;
  logic                 mode_q;
  logic                 loop_q;
  logic                 valid;
  logic                 last;
  logic                 busy;
`ifdef PHASE_OFFSET_EN
  logic signed [PW-1:0] offset_q;
`endif

  logic                 hs;
  logic                 dwell_wrap;
  logic [DW-1:0]        next_cnt;
  logic signed [PW-1:0] next_inc;
  logic signed [PW-1:0] next_phase;
  logic                 next_last;
  logic signed [PW-1:0] ld_start;
  logic signed [PW-1:0] ld_stop;
  logic signed [PW-1:0] ld_step;
  logic [DW-1:0]        ld_dmax;
  logic                 ld_last;

  // Next accumulator/sweep values for an accepted beat, plus the config
  // values that would be latched by a start pulse.
  always_comb begin
    hs         = valid && m_phase_tready;
    dwell_wrap = (dwell_cnt == dwell_max);
    next_cnt   = dwell_wrap ? '0 : dwell_cnt + DW'(1);
    next_inc   = inc;
    if (mode_q && dwell_wrap)
      next_inc = pass_end(inc, step_inc_q, stop_inc_q) ? start_inc_q : inc + step_inc_q;
    next_phase = wrap_add(phase, inc);
    next_last  = mode_q && (next_cnt == dwell_max) &&
                 pass_end(next_inc, step_inc_q, stop_inc_q);

    ld_start   = clamp_inc(i_start_inc);
    ld_stop    = clamp_inc(i_stop_inc);
    ld_step    = clamp_inc(i_step_inc);
    ld_dmax    = (i_dwell == '0) ? '0 : i_dwell - DW'(1);
    ld_last    = i_mode && (ld_dmax == '0) && pass_end(ld_start, ld_step, ld_stop);
  end

  // Control FSM with registered stream outputs; tlast is precomputed so it
  // is aligned with the beat it marks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      phase       <= '0;
      inc         <= '0;
      start_inc_q <= '0;
      stop_inc_q  <= '0;
      step_inc_q  <= '0;
      dwell_max   <= '0;
      dwell_cnt   <= '0;
      mode_q      <= 1'b0;
      loop_q      <= 1'b0;
      valid       <= 1'b0;
      last        <= 1'b0;
      busy        <= 1'b0;
`ifdef PHASE_OFFSET_EN
      offset_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          last  <= 1'b0;
          phase <= '0;
          // Abort dominates a simultaneous start.
          if (i_start && !i_abort) begin
            state       <= RUN;
            start_inc_q <= ld_start;
            stop_inc_q  <= ld_stop;
            step_inc_q  <= ld_step;
            dwell_max   <= ld_dmax;
            mode_q      <= i_mode;
            loop_q      <= i_loop;
            inc         <= ld_start;
            dwell_cnt   <= '0;
            last        <= ld_last;
            valid       <= 1'b1;
            busy        <= 1'b1;
`ifdef PHASE_OFFSET_EN
            offset_q    <= $signed(i_offset);
`endif
          end
        end
        RUN: begin
          if (hs) begin
            if (i_abort || (last && !loop_q)) begin
              state     <= IDLE;
              valid     <= 1'b0;
              busy      <= 1'b0;
              last      <= 1'b0;
              phase     <= '0;
              dwell_cnt <= '0;
            end else begin
              phase     <= next_phase;
              inc       <= next_inc;
              dwell_cnt <= next_cnt;
              last      <= next_last;
            end
          end else if (i_abort) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Hold the pending beat untouched until the consumer takes it.
          if (hs) begin
            state     <= IDLE;
            valid     <= 1'b0;
            busy      <= 1'b0;
            last      <= 1'b0;
            phase     <= '0;
            dwell_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
          last  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PHASE_OFFSET_EN
  assign m_phase_tdata  = wrap_add(phase, offset_q);
`else
  assign m_phase_tdata  = phase;
`endif
  assign m_phase_tvalid = valid;
  assign m_phase_tlast  = last;
  assign o_busy         = busy;

endmodule

`default_nettype wire

// File: tb/tb_phase_sweep_gen.sv
// ============================================================================
// Module   : tb_phase_sweep_gen
// Brief    : Self-checking bench for phase_sweep_gen. Config vectors in a
//            table drive a behavioural phase model whose beats are queued
//            and compared as the DUT hands them over; hand-written sequences
//            cover abort, start/abort collision and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phase_sweep_gen;

  localparam int PI  = 25736;
  localparam int TWO = 51472;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_abort, i_mode, i_loop;
  logic [15:0] i_start_inc, i_stop_inc, i_step_inc, i_dwell;
`ifdef PHASE_OFFSET_EN
  logic [15:0] i_offset;
`endif
  logic [15:0] m_phase_tdata;
  logic        m_phase_tvalid, m_phase_tready, m_phase_tlast, o_busy;

  phase_sweep_gen #(.PW(16), .DW(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_abort        (i_abort),
    .i_mode         (i_mode),
    .i_loop         (i_loop),
    .i_start_inc    (i_start_inc),
    .i_stop_inc     (i_stop_inc),
    .i_step_inc     (i_step_inc),
    .i_dwell        (i_dwell),
`ifdef PHASE_OFFSET_EN
    .i_offset       (i_offset),
`endif
    .m_phase_tdata  (m_phase_tdata),
    .m_phase_tvalid (m_phase_tvalid),
    .m_phase_tready (m_phase_tready),
    .m_phase_tlast  (m_phase_tlast),
    .o_busy         (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic        loop;
    logic [15:0] start_inc;
    logic [15:0] stop_inc;
    logic [15:0] step_inc;
    logic [15:0] dwell;
    int          nbeats;
    logic        abort_end;
    logic        rnd;
    int          chk_idx;
    logic [15:0] chk_val;
  } vec_t;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  vec_t        vecs[8];
  logic [15:0] cap[64];
  logic [15:0] ref_cap[64];
  int          cap_n;
  int          errors = 0;
  int          checks = 0;
  logic        auto_ready, rnd_ready;
  logic        stall_held;
  logic [15:0] held_data;
  logic        held_last;

  // behavioural model state
  int m_mode, m_loop, m_start, m_stop, m_step, m_dmax, m_ph, m_inc, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic int clampi(input int v);
    return (v > PI) ? PI : ((v < -PI) ? -PI : v);
  endfunction

  function automatic int wrapi(input int v);
    return (v > PI) ? v - TWO : ((v < -PI) ? v + TWO : v);
  endfunction

  function automatic int s16(input logic [15:0] x);
    return int'($signed(x));
  endfunction

  function automatic bit pend();
    if (m_step == 0) return 1'b1;
    if (m_step > 0) return (m_inc + m_step) > m_stop;
    return (m_inc + m_step) < m_stop;
  endfunction

  task automatic model_init(input vec_t v);
    m_mode  = int'(v.mode);
    m_loop  = int'(v.loop);
    m_start = clampi(s16(v.start_inc));
    m_stop  = clampi(s16(v.stop_inc));
    m_step  = clampi(s16(v.step_inc));
    m_dmax  = (v.dwell == 16'd0) ? 0 : int'(v.dwell) - 1;
    m_ph    = 0;
    m_inc   = m_start;
    m_cnt   = 0;
  endtask

  // Queue the beat the model currently presents, then advance the model.
  task automatic model_push();
    beat_t b;
    bit    e;
    e      = pend();
    b.data = 16'(m_ph);
    b.last = (m_mode != 0) && (m_cnt == m_dmax) && e;
    exp_q.push_back(b);
    m_ph = wrapi(m_ph + m_inc);
    if (m_mode != 0) begin
      if (m_cnt == m_dmax) begin
        m_cnt = 0;
        m_inc = e ? m_start : m_inc + m_step;
      end else begin
        m_cnt++;
      end
    end
  endtask

  // One clock: choose ready for the coming edge, score the presented beat,
  // then step to 1 ns past the rising edge.
  task automatic cyc();
    beat_t e;
    if (auto_ready)
      m_phase_tready = (exp_q.size() != 0) && (rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1);
    if (stall_held && m_phase_tvalid) begin
      chk("stall_data", 32'(m_phase_tdata), 32'(held_data));
      chk("stall_last", 32'(m_phase_tlast), 32'(held_last));
    end
    if (m_phase_tvalid && m_phase_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %h with nothing expected", m_phase_tdata);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", 32'(m_phase_tdata), 32'(e.data));
        chk("beat_last", 32'(m_phase_tlast), 32'(e.last));
        if (cap_n < 64) cap[cap_n] = m_phase_tdata;
        cap_n++;
      end
    end
    stall_held = m_phase_tvalid && !m_phase_tready;
    held_data  = m_phase_tdata;
    held_last  = m_phase_tlast;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_queue(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      cyc();
      n++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_cfg(input vec_t v);
    i_mode      = v.mode;
    i_loop      = v.loop;
    i_start_inc = v.start_inc;
    i_stop_inc  = v.stop_inc;
    i_step_inc  = v.step_inc;
    i_dwell     = v.dwell;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    model_init(v);
    exp_q.delete();
    cap_n      = 0;
    stall_held = 1'b0;
    for (int i = 0; i < v.nbeats; i++) model_push();
    load_cfg(v);
    rnd_ready  = v.rnd;
    auto_ready = 1'b1;
    i_start    = 1'b1;
    cyc();
    i_start    = 1'b0;
    chk("start_valid", 32'(m_phase_tvalid), 32'd1);
    chk("start_busy", 32'(o_busy), 32'd1);
    drain_queue("beats_left");
    if (!v.abort_end) begin
      chk("end_valid", 32'(m_phase_tvalid), 32'd0);
      chk("end_busy", 32'(o_busy), 32'd0);
    end else begin
      chk("run_valid", 32'(m_phase_tvalid), 32'd1);
      model_push();
      auto_ready     = 1'b0;
      m_phase_tready = 1'b0;
      i_abort        = 1'b1;
      cyc();
      i_abort        = 1'b0;
      repeat (3) cyc();
      chk("drain_busy", 32'(o_busy), 32'd1);
      auto_ready = 1'b1;
      rnd_ready  = 1'b0;
      drain_queue("drain_left");
      chk("abort_valid", 32'(m_phase_tvalid), 32'd0);
      chk("abort_busy", 32'(o_busy), 32'd0);
    end
    chk(nm, 32'(cap[v.chk_idx]), 32'(v.chk_val));
    auto_ready     = 1'b0;
    m_phase_tready = 1'b0;
    cyc();
  endtask

  initial begin
    vecs[0] = '{mode:1'b0, loop:1'b0, start_inc:16'h0400, stop_inc:16'h0000, step_inc:16'h0000,
                dwell:16'd1, nbeats:30, abort_end:1'b1, rnd:1'b0, chk_idx:26, chk_val:16'h9EF0};
    vecs[1] = '{mode:1'b0, loop:1'b0, start_inc:16'hF000, stop_inc:16'h0000, step_inc:16'h0000,
                dwell:16'd1, nbeats:10, abort_end:1'b1, rnd:1'b0, chk_idx:7, chk_val:16'h5910};
    vecs[2] = '{mode:1'b1, loop:1'b0, start_inc:16'h0100, stop_inc:16'h0400, step_inc:16'h0100,
                dwell:16'd3, nbeats:12, abort_end:1'b0, rnd:1'b0, chk_idx:11, chk_val:16'h1A00};
    vecs[3] = '{mode:1'b1, loop:1'b0, start_inc:16'h0100, stop_inc:16'h0400, step_inc:16'h0100,
                dwell:16'd3, nbeats:12, abort_end:1'b0, rnd:1'b1, chk_idx:11, chk_val:16'h1A00};
    vecs[4] = '{mode:1'b0, loop:1'b0, start_inc:16'h7FFF, stop_inc:16'h0000, step_inc:16'h0000,
                dwell:16'd1, nbeats:5, abort_end:1'b1, rnd:1'b0, chk_idx:2, chk_val:16'h0000};
    vecs[5] = '{mode:1'b1, loop:1'b0, start_inc:16'h0100, stop_inc:16'h0300, step_inc:16'h0100,
                dwell:16'd0, nbeats:3, abort_end:1'b0, rnd:1'b0, chk_idx:2, chk_val:16'h0300};
    vecs[6] = '{mode:1'b1, loop:1'b1, start_inc:16'h0100, stop_inc:16'h0200, step_inc:16'h0100,
                dwell:16'd2, nbeats:10, abort_end:1'b1, rnd:1'b0, chk_idx:5, chk_val:16'h0700};
    vecs[7] = '{mode:1'b1, loop:1'b0, start_inc:16'h0300, stop_inc:16'h0100, step_inc:16'hFF00,
                dwell:16'd1, nbeats:3, abort_end:1'b0, rnd:1'b0, chk_idx:2, chk_val:16'h0500};

    rst            = 1'b1;
    i_start        = 1'b0;
    i_abort        = 1'b0;
    i_mode         = 1'b0;
    i_loop         = 1'b0;
    i_start_inc    = '0;
    i_stop_inc     = '0;
    i_step_inc     = '0;
    i_dwell        = '0;
`ifdef PHASE_OFFSET_EN
    i_offset       = '0;
`endif
    m_phase_tready = 1'b0;
    auto_ready     = 1'b0;
    rnd_ready      = 1'b0;
    stall_held     = 1'b0;
    held_data      = '0;
    held_last      = 1'b0;
    cap_n          = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_phase_tvalid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_last", 32'(m_phase_tlast), 32'd0);
    chk("rst_data", 32'(m_phase_tdata), 32'd0);
    rst = 1'b0;
    cyc();

    // table-driven config vectors
    for (int k = 0; k < 8; k++) begin
      run_vec(vecs[k], $sformatf("vec%0d_word", k));
      if (k == 2)
        for (int i = 0; i < 12; i++) ref_cap[i] = cap[i];
      if (k == 3)
        for (int i = 0; i < 12; i++) chk("bp_same_seq", 32'(cap[i]), 32'(ref_cap[i]));
    end

    // start and abort together in IDLE: abort wins
    load_cfg(vecs[0]);
    i_start = 1'b1;
    i_abort = 1'b1;
    cyc();
    i_start = 1'b0;
    i_abort = 1'b0;
    cyc();
    chk("collide_valid", 32'(m_phase_tvalid), 32'd0);
    chk("collide_busy", 32'(o_busy), 32'd0);

    // abort coinciding with a handshake returns straight to IDLE
    model_init(vecs[0]);
    exp_q.delete();
    cap_n = 0;
    for (int i = 0; i < 4; i++) model_push();
    auto_ready     = 1'b0;
    m_phase_tready = 1'b1;
    i_start        = 1'b1;
    cyc();
    i_start        = 1'b0;
    repeat (3) cyc();
    i_abort        = 1'b1;
    cyc();
    i_abort        = 1'b0;
    chk("hsabort_valid", 32'(m_phase_tvalid), 32'd0);
    chk("hsabort_busy", 32'(o_busy), 32'd0);
    chk("hsabort_left", 32'(exp_q.size()), 32'd0);
    m_phase_tready = 1'b0;
    cyc();

    // asynchronous reset in the middle of a sweep beat
    model_init(vecs[2]);
    exp_q.delete();
    cap_n = 0;
    for (int i = 0; i < 12; i++) model_push();
    load_cfg(vecs[2]);
    auto_ready = 1'b1;
    rnd_ready  = 1'b0;
    i_start    = 1'b1;
    cyc();
    i_start    = 1'b0;
    repeat (5) cyc();
    auto_ready     = 1'b0;
    m_phase_tready = 1'b0;
    cyc();
    chk("pre_rst_valid", 32'(m_phase_tvalid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(m_phase_tvalid), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_last", 32'(m_phase_tlast), 32'd0);
    exp_q.delete();
    stall_held = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    chk("post_rst_idle", 32'(m_phase_tvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/phase_sweep_gen.md
# phase_sweep_gen

Phase-stream source for the CORDIC sine/cosine wave generator. It emits wrapped radian phase words in signed 1.2.13 fixed point over an AXI-Stream style valid/ready link and supports two modes: a constant-increment tone and a linear frequency sweep (chirp) with programmable dwell. The phase advances only on accepted beats, so CORDIC back-pressure never corrupts the waveform.

## Interface
- PW, 16: phase and increment width, signed 1.2.13 fixed point
- DW, 16: dwell counter width
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_start  in  1  single-cycle pulse; latches the config inputs and begins output
- i_abort  in  1  single-cycle pulse; stops output after the pending beat is accepted
- i_mode  in  1  0 = tone, 1 = sweep; latched on i_start
- i_loop  in  1  1 = restart the sweep at its end, 0 = stop; latched on i_start
- i_start_inc  in  PW  signed phase increment for tone mode and for the start of a sweep
- i_stop_inc  in  PW  signed final sweep increment
- i_step_inc  in  PW  signed increment delta applied per dwell period
- i_dwell  in  DW  accepted beats per increment value; 0 is treated as 1
- m_phase_tdata  out  PW  phase word for the CORDIC phase input
- m_phase_tvalid  out  1  phase word valid
- m_phase_tready  in  1  consumer ready
- m_phase_tlast  out  1  marks the final beat of each sweep pass
- o_busy  out  1  high in any state other than IDLE

## Operation
- Constants: PI_POS = 0x6488 (+25736), PI_NEG = 0x9B78 (-25736), TWO_PI = 51472.
- Clamping: every latched increment is clamped to [PI_NEG, PI_POS].
- Accumulation: phase is accumulated in PW+2 bits.
  - If next > PI_POS, subtract TWO_PI.
  - If next < PI_NEG, add TWO_PI.
  - The result is always in [PI_NEG, PI_POS] with no saturation; positive and negative increments wrap symmetrically.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - tvalid = 0, phase register = 0.
  - i_start (without i_abort) moves to RUN and latches all config inputs; the increment register is loaded with start_inc.
- RUN:
  - tvalid = 1 continuously.
  - On each handshake (tvalid & tready): phase ← wrap(phase + inc) and the dwell counter increments.
  - Tone mode: inc stays constant and tlast = 0.
  - Sweep mode: when the dwell counter reaches dwell-1 on a handshake, it clears and inc ← inc + step. The pass ends when the next inc would pass stop_inc in the direction of step (with step = 0, after one dwell period).
  - The final beat of the last dwell period carries tlast = 1.
  - End of pass with loop = 1: inc ← start_inc and phase continues (not reset).
  - End of pass with loop = 0: go to IDLE; tvalid drops the following cycle.
- Abort: i_abort in RUN moves to DRAIN. DRAIN holds the current beat (data and tvalid stable) until it is accepted, then goes to IDLE. An abort pulse asserted in the same cycle as a handshake goes directly to IDLE.
- Start and abort together in IDLE: abort wins and the block stays IDLE. i_start in RUN or DRAIN is ignored.
- AXI rule: while tvalid = 1 and tready = 0, tdata and tlast are stable.

## Timing
- Reset values: tdata = 0, tvalid = 0, tlast = 0, o_busy = 0, state = IDLE, inc = 0, dwell counter = 0. Reset is asynchronous and takes effect mid-beat; no drain.
- i_start at edge N: tvalid = 1 and tdata = 0 from edge N+1. This first beat is phase 0.
- Handshake at edge K: the new tdata is visible after edge K. Throughput is one beat per cycle when tready is held high.
- o_busy is registered and asserts together with tvalid.
- After a tlast handshake with loop = 0, tvalid = 0 from the following edge.

## Configuration
- PHASE_OFFSET_EN:
  - Defined: adds input i_offset (PW, signed 1.2.13, latched on i_start). The output is wrap(phase + offset), computed combinationally from registered values with no added latency. The accumulator itself is unaffected.
  - Undefined: no port, and tdata equals the accumulator.

## Test plan
- Tone: start_inc = 0x0400, tready = 1. Required output: 0x0000, 0x0400, 0x0800, …; after the word 0x6400 the next word is 0x6800-51472 = 0x9B78+0x0400-0x88+… (check against the wrap formula), with no value ever above 0x6488.
- Negative tone: start_inc = -0x1000. Required: the phase decrements and wraps below PI_NEG to a positive value ≤ PI_POS.
- Sweep: start = 0x0100, stop = 0x0400, step = 0x0100, dwell = 3, loop = 0. Required: 12 beats at increments 0x100, 0x200, 0x300, 0x400 (3 each); tlast on beat 12; tvalid low the cycle after.
- Back-pressure: random tready at 50% during the sweep. Required: an identical tdata sequence to the tready = 1 run, and data stable while stalled.
- Abort with tready = 0: i_abort pulse. Required: the same beat is held until tready = 1, one handshake occurs, then IDLE with o_busy = 0.
- Async reset asserted mid-sweep between clock edges. Required: tvalid and o_busy go to 0 immediately, with no clock edge needed.
